botsw_ocp_ctrl: RTL

//  Digital over-current protection and gate-enable controller for the low-side (BOT) power NMOS switch.

---
 rtl/botsw_ocp_pkg.sv | 26 ++
 rtl/botsw_ocp_sync.sv | 23 ++
 rtl/botsw_ocp_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/botsw_ocp_pkg.sv
// Shared types for the low-side switch over-current controller: FSM states,
// debug state codes and a timer width helper.
package botsw_ocp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BLANK = 3'd1,
    S_ON    = 3'd2,
    S_COOL  = 3'd3,
    S_LATCH = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BLANK = 3'd1;
  localparam logic [2:0] ST_ON    = 3'd2;
  localparam logic [2:0] ST_COOL  = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  // Width of the shared blank/cool timer, never narrower than one bit.
  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/botsw_ocp_sync.sv
// Two-flop synchronizer for the asynchronous replica-current comparator.
module botsw_ocp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/botsw_ocp_ctrl.sv
// BOT switch gate-enable controller: leading-edge blanking, OC glitch filter,
// hiccup cool-down, bounded retry and latch-off.
module botsw_ocp_ctrl
  import botsw_ocp_pkg::*;
#(
  parameter int BLANK_CYC = 8,
  parameter int FILT_CYC  = 3,
  parameter int COOL_CYC  = 256,
  parameter int MAX_RETRY = 4,
  parameter int RW        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          pwm_i,
  input  logic          oc_cmp_i,
  output logic          gate_en_o,
  output logic          oc_event_o,
  output logic          fault_latched_o,
  output logic [RW-1:0] retry_cnt_o,
  output logic [2:0]    state_o
);

  localparam int TW = tmr_w(BLANK_CYC, COOL_CYC);
  localparam int FW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC + 1);

  localparam logic [TW-1:0] T_BLANK_END = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] T_COOL_END  = TW'(COOL_CYC - 1);
  localparam logic [TW-1:0] T_MAX       = '1;
  localparam logic [FW-1:0] F_END       = FW'(FILT_CYC - 1);
  localparam logic [RW-1:0] R_MAX       = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   filt_q, filt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            gate_q, gate_d;
  logic            evt_q, evt_d;
  logic            pwm_q;
  logic            oc_s, pwm_rise, oc_decl;

  botsw_ocp_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (oc_cmp_i),
    .q_o   (oc_s)
  );

  assign pwm_rise = pwm_i & ~pwm_q;
  // Declared on the FILT_CYC-th consecutive sample, not one edge after it.
  assign oc_decl  = (state_q == S_ON) && oc_s && (filt_q == F_END);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    evt_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (pwm_rise) state_d = S_BLANK;
      S_BLANK: begin
        if (!pwm_i)                      state_d = S_IDLE;
        else if (timer_q == T_BLANK_END) state_d = S_ON;
      end
      S_ON: begin
        if (oc_decl) begin
          state_d = S_COOL;
          evt_d   = 1'b1;
          retry_d = (retry_q == R_MAX) ? retry_q : retry_q + RW'(1);
        end else if (!pwm_i) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end
      S_COOL:  if (timer_q == T_COOL_END) state_d = (retry_q == R_MAX) ? S_LATCH : S_IDLE;
      S_LATCH: state_d = S_LATCH;
      default: state_d = S_IDLE;
    endcase
    if (!en_i) begin
      state_d = S_IDLE;
      retry_d = '0;
      evt_d   = 1'b0;
    end

    if (!en_i || (state_d != state_q)) timer_d = '0;
    else if (timer_q != T_MAX)         timer_d = timer_q + TW'(1);
    else                               timer_d = timer_q;

    if (en_i && (state_q == S_ON) && (state_d == S_ON) && oc_s)
      filt_d = (filt_q == F_END) ? filt_q : filt_q + FW'(1);
    else
      filt_d = '0;

    // Gate follows the registered state, with EN=0 cutting it on the next edge.
    gate_d = en_i && ((state_q == S_BLANK) || (state_q == S_ON));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      filt_q  <= '0;
      retry_q <= '0;
      gate_q  <= 1'b0;
      evt_q   <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      filt_q  <= filt_d;
      retry_q <= retry_d;
      gate_q  <= gate_d;
      evt_q   <= evt_d;
      pwm_q   <= pwm_i;
    end
  end

  assign gate_en_o       = gate_q;
  assign oc_event_o      = evt_q;
  assign fault_latched_o = (state_q == S_LATCH);
  assign retry_cnt_o     = retry_q;
  assign state_o         = state_q;

endmodule
